spi_frame_capture_avalon: RTL and testbench
===========================================

# spi_frame_capture_avalon

Parametrised SPI bus-monitor debug block. It assembles byte streams from the MOSI and MISO shift buffers into fixed-length frames and commits each frame, tagged, into a ring buffer readable over an Avalon-MM slave. It adds configurable frame length and depth, chip-select resynchronisation, freeze/clear control, overflow accounting and a registered read path.

## Interface
- FRAME_BYTES, 7: data bytes per frame, legal range 1..7.
- ADDR_W, 6: address width. Word 0 is status/control; ring entries occupy words 1..2^ADDR_W-1.
- STOP_ON_FULL, 0: 1 auto-freezes when the ring would wrap; 0 overwrites the oldest entry.
- clock  in  1  single clock domain.
- reset  in  1  reset, synchronous, active-high.
- io_Avalon_address  in  ADDR_W  word address.
- io_Avalon_read  in  1  read request.
- io_Avalon_readdata  out  64  registered read data.
- io_Avalon_write  in  1  write request.
- io_Avalon_writedata  in  64  write data; only address 0 is decoded.
- io_Avalon_waitrequest  out  1  stall.
- io_MOSI_Buffer / io_MISO_Buffer  in  8  completed byte from each shift register.
- io_MOSI_BufferChanged / io_MISO_BufferChanged  in  1  byte strobe, asynchronous level.
- io_CS_n  in  1  SPI chip select, asynchronous, active-low.

## Operation
- Strobe and CS synchronisers:
  - Each strobe and io_CS_n passes through 3 flops s1→s2→s3.
  - A channel event occurs in the cycle where s2=1 and s3=0.
  - A CS release occurs in the cycle where CS s2=1 and CS s3=0.
- Byte assembly, per channel:
  - In an event cycle, the Buffer input is stored at byte index cnt, then cnt increments.
  - When cnt==FRAME_BYTES-1, the frame is complete and cnt returns to 0.
- CS release: both channels' cnt reset to 0 and partial frames are discarded. No entry is written and the drop count is unchanged.
- Entry format:
  - bits [8k+15:8k+8] hold byte k for k<FRAME_BYTES; unused bytes are 0.
  - bit0 = channel (0 MOSI, 1 MISO).
  - bits [7:1] = 7-bit frame sequence number, a global counter that increments once per committed entry and wraps at 128.
- Commit:
  - A completed frame is written at wr_ptr.
  - wr_ptr advances 1→2^ADDR_W-1 and then back to 1; word 0 is never written by capture.
  - Wrapping from the top entry to 1 sets the sticky wrapped flag.
- Simultaneous MOSI and MISO completion:
  - MOSI goes to wr_ptr and MISO to next(wr_ptr).
  - Sequence numbers are n and n+1; the pointer advances by 2 with wrap applied per step.
- Status word (read at address 0):
  - [ADDR_W-1:0] = wr_ptr
  - [16] = wrapped
  - [17] = frozen
  - [18] = MOSI partial (cnt≠0)
  - [19] = MISO partial (cnt≠0)
  - [47:32] = drop count, saturating at 0xFFFF
  - all other bits 0
- Control (write at address 0):
  - writedata[0]=1 performs a clear: wr_ptr=1, wrapped=0, drop=0, seq=0, both cnt=0.
  - writedata[1] is loaded into frozen.
  - Clear and the freeze load apply in the same cycle.
  - Writes to any other address are accepted and ignored.
- Frozen behaviour: bytes are still assembled, but each completed frame increments drop instead of committing. Two simultaneous completions add 2.
- STOP_ON_FULL=1: a commit that would wrap the pointer to 1 instead sets frozen and counts a drop. The top entry is kept.
- Ring contents are not cleared by reset or clear; entries read back as X until they are written.

## Timing
- Reset values: readdata=0, waitrequest=0, wr_ptr=1, wrapped=0, frozen=0, drop=0, seq=0, cnt=0.
- Reset initialises the synchronisers to 1, so strobes already high at reset do not generate events.
- Event latency: a strobe rising edge produces an event 2–3 cycles later.
- Data hold: upstream must hold the Buffer value stable for ≥4 cycles after the strobe rises.
- Commit timing: for a completion in cycle E, the entry and pointer update are visible to reads from cycle E+2.
- Read handshake:
  - First cycle of a read: waitrequest=1 and the RAM or status is sampled.
  - Next cycle: waitrequest=0 and readdata is valid; the master holds read until then.
  - readdata holds its value until the next read.
- Write handshake: waitrequest=0 and the write takes effect at the end of that cycle.
- Control versus capture in the same cycle:
  - A control write wins over a capture commit in that cycle.
  - A commit that coincides with a clear is discarded and not counted.

## Test plan
- FRAME_BYTES=7; drive 7 MOSI bytes 0x11..0x77 with CS low:
  - read addr 1 → 0x7766554433221100 with tag 0x00;
  - status wr_ptr=2.
- Simultaneous 7-byte MOSI and MISO frames:
  - addr1 tag 0x00 (MOSI, seq 0);
  - addr2 tag 0x03 (MISO, seq 1);
  - wr_ptr=3.
- CS release after 3 bytes, then 7 new bytes:
  - exactly one entry holding only the new bytes;
  - drop=0.
- ADDR_W=3, STOP_ON_FULL=0; commit 8 frames:
  - 8th frame lands at addr 1, wrapped=1, wr_ptr=2.
- ADDR_W=3, STOP_ON_FULL=1; commit 9 frames:
  - entries 1..7 written, frozen=1, drop=2;
  - write 0x1 → status reads wr_ptr=1, wrapped=0, frozen=0, drop=0.
- Freeze via write 0x2, send 3 frames, then reset mid-frame:
  - before reset: drop=3;
  - after reset: status equals the reset value and no spurious entry is written.

Source files
------------

// File: rtl/spi_frame_capture_avalon_if.sv
// Avalon-MM slave bus used by the SPI frame capture block.
// Ports: address, read, readdata, write, writedata, waitrequest.
// Master drives the request, slave returns readdata and waitrequest.
interface spi_frame_capture_avalon_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic [63:0]       readdata;
    logic              write;
    logic [63:0]       writedata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/spi_frame_capture_avalon.sv
// SPI bus monitor: assembles MOSI/MISO bytes into tagged frames and commits them to a ring read over Avalon-MM.
// Ports: clock/reset, io_avalon (word 0 status/control, words 1.. ring), MOSI/MISO byte + async strobe, async CS_n.
// Latency: event 2-3 cycles after strobe rise, entry readable 2 cycles after completion; reads take 2 cycles (1 wait).
module spi_frame_capture_avalon #(
    parameter int FRAME_BYTES  = 7,
    parameter int ADDR_W       = 6,
    parameter bit STOP_ON_FULL = 1'b0
) (
    input  logic                        clock,
    input  logic                        reset,
    spi_frame_capture_avalon_if.slave   io_avalon,
    input  logic [7:0]                  io_MOSI_Buffer,
    input  logic [7:0]                  io_MISO_Buffer,
    input  logic                        io_MOSI_BufferChanged,
    input  logic                        io_MISO_BufferChanged,
    input  logic                        io_CS_n
);
    localparam int                CNT_W     = 3;
    localparam int                FW        = 8 * FRAME_BYTES;
    localparam logic [ADDR_W-1:0] PTR_TOP   = '1;
    localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_BYTES - 1);

    // Synchronisers preset to 1 so a strobe already high at reset is not an edge.
    logic [2:0] sync_mosi, sync_miso, sync_cs;
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_mosi <= '1;
            sync_miso <= '1;
            sync_cs   <= '1;
        end else begin
            sync_mosi <= {sync_mosi[1:0], io_MOSI_BufferChanged};
            sync_miso <= {sync_miso[1:0], io_MISO_BufferChanged};
            sync_cs   <= {sync_cs[1:0], io_CS_n};
        end
    end

    logic [1:0] evt;
    logic       cs_rel;
    assign evt[0] = sync_mosi[1] & ~sync_mosi[2];
    assign evt[1] = sync_miso[1] & ~sync_miso[2];
    assign cs_rel = sync_cs[1] & ~sync_cs[2];

    logic ctrl_wr, clr;
    assign ctrl_wr = io_avalon.write && (io_avalon.address == '0);
    assign clr     = ctrl_wr && io_avalon.writedata[0];

    // Byte assembly; channel 0 = MOSI, 1 = MISO.
    logic [7:0]       byte_in   [2];
    logic [CNT_W-1:0] cnt       [2];
    logic [FW-1:0]    asm_buf   [2];
    logic [FW-1:0]    frame_dat [2];
    logic [FW-1:0]    pend_dat  [2];
    logic [1:0]       pend_vld;

    assign byte_in[0] = io_MOSI_Buffer;
    assign byte_in[1] = io_MISO_Buffer;

    // Frame as it stands once this cycle's byte is merged in.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            frame_dat[c] = asm_buf[c];
            for (int k = 0; k < FRAME_BYTES; k++) begin
                if (cnt[c] == CNT_W'(k)) frame_dat[c][8*k +: 8] = byte_in[c];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_vld <= '0;
            for (int c = 0; c < 2; c++) begin
                cnt[c]      <= '0;
                asm_buf[c]  <= '0;
                pend_dat[c] <= '0;
            end
        end else begin
            pend_vld <= '0;
            for (int c = 0; c < 2; c++) begin
                if (clr || cs_rel) begin
                    cnt[c] <= '0;
                end else if (evt[c]) begin
                    asm_buf[c] <= frame_dat[c];
                    if (cnt[c] == CNT_LAST) begin
                        cnt[c]      <= '0;
                        pend_vld[c] <= 1'b1;
                        pend_dat[c] <= frame_dat[c];
                    end else begin
                        cnt[c] <= cnt[c] + 1'b1;
                    end
                end
            end
        end
    end

    // Commit state. top_full marks that the top entry holds data in stop-on-full mode.
    logic [ADDR_W-1:0] wr_ptr;
    logic              wrapped, frozen, top_full;
    logic [6:0]        seq;
    logic [15:0]       drop;
    logic [63:0]       mem [0:(2**ADDR_W)-1];

    logic [ADDR_W-1:0] nxt_ptr;
    logic              nxt_wrapped, nxt_frozen, nxt_full;
    logic [6:0]        nxt_seq;
    logic [1:0]        drop_inc;
    logic [1:0]        we;
    logic [ADDR_W-1:0] wa [2];
    logic [63:0]       wd [2];
    logic [16:0]       drop_sum;

    // MOSI is processed before MISO so simultaneous frames get consecutive slots and tags.
    always_comb begin
        nxt_ptr     = wr_ptr;
        nxt_wrapped = wrapped;
        nxt_frozen  = frozen;
        nxt_full    = top_full;
        nxt_seq     = seq;
        drop_inc    = 2'd0;
        we          = 2'b00;
        for (int c = 0; c < 2; c++) begin
            wa[c] = wr_ptr;
            wd[c] = '0;
        end
        for (int c = 0; c < 2; c++) begin
            if (pend_vld[c]) begin
                if (nxt_frozen) begin
                    drop_inc = drop_inc + 2'd1;
                end else if (STOP_ON_FULL && nxt_full) begin
                    nxt_frozen = 1'b1;
                    drop_inc   = drop_inc + 2'd1;
                end else begin
                    we[c]          = 1'b1;
                    wa[c]          = nxt_ptr;
                    wd[c][8 +: FW] = pend_dat[c];
                    wd[c][7:1]     = nxt_seq;
                    wd[c][0]       = (c == 1);
                    nxt_seq        = nxt_seq + 7'd1;
                    if (nxt_ptr == PTR_TOP) begin
                        if (STOP_ON_FULL) begin
                            nxt_full = 1'b1;
                        end else begin
                            nxt_ptr     = PTR_FIRST;
                            nxt_wrapped = 1'b1;
                        end
                    end else begin
                        nxt_ptr = nxt_ptr + 1'b1;
                    end
                end
            end
        end
    end

    assign drop_sum = {1'b0, drop} + 17'(drop_inc);

    // A control write in the commit cycle takes priority; that cycle's commit is discarded.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= PTR_FIRST;
            wrapped  <= 1'b0;
            frozen   <= 1'b0;
            top_full <= 1'b0;
            seq      <= '0;
            drop     <= '0;
        end else if (ctrl_wr) begin
            frozen <= io_avalon.writedata[1];
            if (io_avalon.writedata[0]) begin
                wr_ptr   <= PTR_FIRST;
                wrapped  <= 1'b0;
                top_full <= 1'b0;
                seq      <= '0;
                drop     <= '0;
            end
        end else begin
            wr_ptr   <= nxt_ptr;
            wrapped  <= nxt_wrapped;
            frozen   <= nxt_frozen;
            top_full <= nxt_full;
            seq      <= nxt_seq;
            drop     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Ring storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (!reset && !ctrl_wr) begin
            for (int c = 0; c < 2; c++) begin
                if (we[c]) mem[wa[c]] <= wd[c];
            end
        end
    end

    logic [63:0] status;
    always_comb begin
        status                 = '0;
        status[ADDR_W-1:0]     = wr_ptr;
        status[16]             = wrapped;
        status[17]             = frozen;
        status[18]             = (cnt[0] != '0);
        status[19]             = (cnt[1] != '0);
        status[47:32]          = drop;
    end

    // Two-cycle read: sample in the wait cycle, present data the next.
    logic rd_phase;
    assign io_avalon.waitrequest = io_avalon.read & ~rd_phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_phase           <= 1'b0;
            io_avalon.readdata <= '0;
        end else if (io_avalon.read && !rd_phase) begin
            rd_phase           <= 1'b1;
            io_avalon.readdata <= (io_avalon.address == '0) ? status : mem[io_avalon.address];
        end else begin
            rd_phase <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_frame_capture_avalon.sv
module tb_spi_frame_capture_avalon;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] mosi_b, miso_b;
    logic       mosi_c, miso_c, cs_n;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    spi_frame_capture_avalon_if #(.ADDR_W(6)) av0 ();
    spi_frame_capture_avalon_if #(.ADDR_W(3)) av1 ();
    spi_frame_capture_avalon_if #(.ADDR_W(3)) av2 ();

    spi_frame_capture_avalon #(.FRAME_BYTES(7), .ADDR_W(6), .STOP_ON_FULL(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .io_avalon(av0),
        .io_MOSI_Buffer(mosi_b), .io_MISO_Buffer(miso_b),
        .io_MOSI_BufferChanged(mosi_c), .io_MISO_BufferChanged(miso_c), .io_CS_n(cs_n));

    spi_frame_capture_avalon #(.FRAME_BYTES(7), .ADDR_W(3), .STOP_ON_FULL(1'b0)) u_dut1 (
        .clock(clock), .reset(reset), .io_avalon(av1),
        .io_MOSI_Buffer(mosi_b), .io_MISO_Buffer(miso_b),
        .io_MOSI_BufferChanged(mosi_c), .io_MISO_BufferChanged(miso_c), .io_CS_n(cs_n));

    spi_frame_capture_avalon #(.FRAME_BYTES(7), .ADDR_W(3), .STOP_ON_FULL(1'b1)) u_dut2 (
        .clock(clock), .reset(reset), .io_avalon(av2),
        .io_MOSI_Buffer(mosi_b), .io_MISO_Buffer(miso_b),
        .io_MOSI_BufferChanged(mosi_c), .io_MISO_BufferChanged(miso_c), .io_CS_n(cs_n));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_set(input int d, input logic [5:0] a, input logic rd, input logic wr,
                           input logic [63:0] wdat);
        case (d)
            0: begin av0.address = a;      av0.read = rd; av0.write = wr; av0.writedata = wdat; end
            1: begin av1.address = a[2:0]; av1.read = rd; av1.write = wr; av1.writedata = wdat; end
            default: begin av2.address = a[2:0]; av2.read = rd; av2.write = wr; av2.writedata = wdat; end
        endcase
    endtask

    function automatic logic get_wait(input int d);
        case (d)
            0:       return av0.waitrequest;
            1:       return av1.waitrequest;
            default: return av2.waitrequest;
        endcase
    endfunction

    function automatic logic [63:0] get_rdata(input int d);
        case (d)
            0:       return av0.readdata;
            1:       return av1.readdata;
            default: return av2.readdata;
        endcase
    endfunction

    task automatic av_write(input int d, input logic [5:0] a, input logic [63:0] v);
        @(posedge clock); #1;
        bus_set(d, a, 1'b0, 1'b1, v);
        @(posedge clock); #1;
        bus_set(d, 6'd0, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic av_read(input int d, input logic [5:0] a, output logic [63:0] q);
        int n;
        @(posedge clock); #1;
        bus_set(d, a, 1'b1, 1'b0, 64'd0);
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (get_wait(d) && n < 8);
        if (get_wait(d)) begin
            total++;
            bad++;
            $display("FAIL read_timeout dut%0d: waitrequest still 1 after %0d cycles, expected 0", d, n);
        end
        q = get_rdata(d);
        @(posedge clock); #1;
        bus_set(d, 6'd0, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic read_check(input string name, input int d, input logic [5:0] a,
                              input logic [63:0] exp);
        logic [63:0] q;
        av_read(d, a, q);
        check(name, q, exp);
    endtask

    task automatic send_byte(input logic [7:0] mo, input logic [7:0] mi, input logic dmo, input logic dmi);
        @(posedge clock); #1;
        mosi_b = mo;
        miso_b = mi;
        @(posedge clock); #1;
        mosi_c = dmo;
        miso_c = dmi;
        repeat (5) @(posedge clock);
        #1;
        mosi_c = 1'b0;
        miso_c = 1'b0;
        repeat (4) @(posedge clock);
    endtask

    task automatic send_frame(input logic [55:0] mo, input logic [55:0] mi, input logic dmo, input logic dmi);
        for (int k = 0; k < 7; k++) send_byte(mo[8*k +: 8], mi[8*k +: 8], dmo, dmi);
        repeat (4) @(posedge clock);
    endtask

    typedef struct {
        logic [55:0] mo;
        logic [55:0] mi;
        logic        use_mo;
        logic        use_mi;
        logic [63:0] exp1;
        logic [63:0] exp2;
        logic [63:0] exp_stat;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [55:0] fr;

        vecs[0] = '{56'h77665544332211, 56'h0, 1'b1, 1'b0,
                    64'h7766554433221100, 64'h0, 64'h2};
        vecs[1] = '{56'h77665544332211, 56'h07060504030201, 1'b1, 1'b1,
                    64'h7766554433221100, 64'h0706050403020103, 64'h3};
        vecs[2] = '{56'h0, 56'hF6F5F4F3F2F1F0, 1'b0, 1'b1,
                    64'hF6F5F4F3F2F1F001, 64'h0, 64'h2};
        vecs[3] = '{56'h5AFF00EFBEADDE, 56'h0, 1'b1, 1'b0,
                    64'h5AFF00EFBEADDE00, 64'h0, 64'h2};

        reset  = 1'b1;
        cs_n   = 1'b0;
        mosi_b = 8'h00;
        miso_b = 8'h00;
        mosi_c = 1'b0;
        miso_c = 1'b0;
        for (int d = 0; d < 3; d++) bus_set(d, 6'd0, 1'b0, 1'b0, 64'd0);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state and read handshake
        check("rst_readdata", av0.readdata, 64'h0);
        check("rst_waitrequest", {63'd0, av0.waitrequest}, 64'h0);
        check("rst_readdata_stop", av2.readdata, 64'h0);
        @(posedge clock); #1;
        bus_set(0, 6'd0, 1'b1, 1'b0, 64'd0);
        #1;
        check("wait_first_cycle", {63'd0, av0.waitrequest}, 64'h1);
        @(posedge clock); #1;
        check("wait_second_cycle", {63'd0, av0.waitrequest}, 64'h0);
        check("rst_status", av0.readdata, 64'h1);
        @(posedge clock); #1;
        bus_set(0, 6'd0, 1'b0, 1'b0, 64'd0);
        @(posedge clock); #1;
        check("readdata_hold", av0.readdata, 64'h1);

        // Table-driven single/simultaneous frames
        for (int i = 0; i < 4; i++) begin
            av_write(0, 6'd0, 64'h1);
            send_frame(vecs[i].mo, vecs[i].mi, vecs[i].use_mo, vecs[i].use_mi);
            read_check($sformatf("vec%0d_addr1", i), 0, 6'd1, vecs[i].exp1);
            if (vecs[i].use_mo && vecs[i].use_mi)
                read_check($sformatf("vec%0d_addr2", i), 0, 6'd2, vecs[i].exp2);
            read_check($sformatf("vec%0d_status", i), 0, 6'd0, vecs[i].exp_stat);
        end

        // CS release discards a partial frame
        av_write(0, 6'd0, 64'h1);
        send_byte(8'hA1, 8'h00, 1'b1, 1'b0);
        send_byte(8'hA2, 8'h00, 1'b1, 1'b0);
        send_byte(8'hA3, 8'h00, 1'b1, 1'b0);
        read_check("cs_partial_status", 0, 6'd0, 64'h40001);
        @(posedge clock); #1;
        cs_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        cs_n = 1'b0;
        repeat (5) @(posedge clock);
        read_check("cs_released_status", 0, 6'd0, 64'h1);
        send_frame(56'h27262524232221, 56'h0, 1'b1, 1'b0);
        read_check("cs_new_entry", 0, 6'd1, 64'h2726252423222100);
        read_check("cs_status_after", 0, 6'd0, 64'h2);

        // Ring wrap (dut1) and stop-on-full (dut2), ADDR_W=3
        av_write(1, 6'd0, 64'h1);
        av_write(2, 6'd0, 64'h1);
        for (int f = 1; f <= 8; f++) begin
            fr = {7{8'(f)}};
            send_frame(fr, 56'h0, 1'b1, 1'b0);
        end
        read_check("wrap_addr1", 1, 6'd1, 64'h080808080808080E);
        read_check("wrap_status", 1, 6'd0, 64'h0000_0000_0001_0002);
        fr = {7{8'h09}};
        send_frame(fr, 56'h0, 1'b1, 1'b0);
        read_check("stop_status", 2, 6'd0, 64'h0000_0002_0002_0007);
        read_check("stop_addr7", 2, 6'd7, 64'h070707070707070C);
        read_check("stop_addr1", 2, 6'd1, 64'h0101010101010100);
        av_write(2, 6'd0, 64'h1);
        read_check("stop_after_clear", 2, 6'd0, 64'h1);

        // Freeze, then reset in the middle of a frame
        av_write(0, 6'd0, 64'h1);
        av_write(0, 6'd0, 64'h2);
        send_frame(56'h11111111111111, 56'h0, 1'b1, 1'b0);
        send_frame(56'h22222222222222, 56'h0, 1'b1, 1'b0);
        send_frame(56'h33333333333333, 56'h0, 1'b1, 1'b0);
        read_check("freeze_status", 0, 6'd0, 64'h0000_0003_0002_0001);
        send_byte(8'h44, 8'h00, 1'b1, 1'b0);
        send_byte(8'h45, 8'h00, 1'b1, 1'b0);
        @(posedge clock); #1;
        mosi_b = 8'h46;
        mosi_c = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("midreset_readdata", av0.readdata, 64'h0);
        repeat (3) @(posedge clock);
        #1;
        mosi_c = 1'b0;
        repeat (10) @(posedge clock);
        read_check("midreset_status", 0, 6'd0, 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
